// File: rtl/snoop_bus_rr.sv
// Registered round-robin snooping-bus arbiter with a grant handshake and a memory-reply wait phase.
// Optional macro SNOOP_BUS_TIMEOUT_EN adds a WAIT_MEM watchdog that raises timeout_err.
module snoop_bus_rr #(
  parameter int N_PROC = 3,
  parameter int MSG_W = 9,
  parameter int OP_W = 2,
  parameter logic [OP_W-1:0] IDLE_OP = 2'b00,
  parameter logic [OP_W-1:0] READ_MISS_OP = 2'b01,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                    i_clock,
  input  logic                    i_reset,
  input  logic [N_PROC*MSG_W-1:0] i_proc_msg,
  input  logic [MSG_W-1:0]        i_mem_msg,
  input  logic                    i_mem_valid,
  output logic                    o_mem_ready,
  output logic [MSG_W-1:0]        o_bus_msg,
  output logic                    o_bus_valid,
  output logic [N_PROC-1:0]       o_grant,
  output logic                    o_timeout_err
);

  localparam int PTR_W = $clog2(N_PROC);
  localparam logic [MSG_W-1:0] IDLE_MSG = {IDLE_OP, {(MSG_W-OP_W){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_BCAST, S_WAIT_MEM} state_t;

  state_t             r_state;
  logic [PTR_W-1:0]   r_rr_ptr;
  logic [MSG_W-1:0]   r_bus_msg;
  logic               r_bus_valid;
  logic [N_PROC-1:0]  r_grant;
  logic               r_from_proc;
  logic [OP_W-1:0]    r_op;

  logic [N_PROC-1:0]  w_active;
  logic               w_found;
  logic [MSG_W-1:0]   w_win_msg;
  logic [N_PROC-1:0]  w_win_onehot;
  logic [PTR_W-1:0]   w_next_ptr;
  int                 w_idx;

  always_comb begin
    for (int i = 0; i < N_PROC; i++) begin
      w_active[i] = (i_proc_msg[i*MSG_W + MSG_W-1 -: OP_W] != IDLE_OP);
    end
  end

  // First active port at or after rr_ptr, wrapping modulo N_PROC.
  always_comb begin
    w_found      = 1'b0;
    w_win_msg    = IDLE_MSG;
    w_win_onehot = '0;
    w_next_ptr   = '0;
    w_idx        = 0;
    for (int k = 0; k < N_PROC; k++) begin
      w_idx = int'(r_rr_ptr) + k;
      if (w_idx >= N_PROC) w_idx = w_idx - N_PROC;
      if (!w_found && w_active[w_idx]) begin
        w_found             = 1'b1;
        w_win_msg           = i_proc_msg[w_idx*MSG_W +: MSG_W];
        w_win_onehot[w_idx] = 1'b1;
        w_next_ptr          = (w_idx + 1 >= N_PROC) ? '0 : PTR_W'(w_idx + 1);
      end
    end
  end

  assign o_mem_ready = ((r_state == S_IDLE) && !w_found) || (r_state == S_WAIT_MEM);
  assign o_bus_msg   = r_bus_msg;
  assign o_bus_valid = r_bus_valid;
  assign o_grant     = r_grant;

`ifdef SNOOP_BUS_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] r_cnt;
  logic             r_timeout_err;
  assign o_timeout_err = r_timeout_err;
`else
  assign o_timeout_err = 1'b0;
`endif

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state     <= S_IDLE;
      r_rr_ptr    <= '0;
      r_bus_msg   <= IDLE_MSG;
      r_bus_valid <= 1'b0;
      r_grant     <= '0;
      r_from_proc <= 1'b0;
      r_op        <= IDLE_OP;
`ifdef SNOOP_BUS_TIMEOUT_EN
      r_cnt         <= '0;
      r_timeout_err <= 1'b0;
`endif
    end else begin
`ifdef SNOOP_BUS_TIMEOUT_EN
      r_timeout_err <= 1'b0;
`endif
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_bus_msg   <= w_win_msg;
            r_bus_valid <= 1'b1;
            r_grant     <= w_win_onehot;
            r_rr_ptr    <= w_next_ptr;
            r_from_proc <= 1'b1;
            r_op        <= w_win_msg[MSG_W-1 -: OP_W];
            r_state     <= S_BCAST;
          end else if (i_mem_valid) begin
            r_bus_msg   <= i_mem_msg;
            r_bus_valid <= 1'b1;
            r_grant     <= '0;
            r_from_proc <= 1'b0;
            r_state     <= S_BCAST;
          end else begin
            r_bus_msg   <= IDLE_MSG;
            r_bus_valid <= 1'b0;
            r_grant     <= '0;
          end
        end
        S_BCAST: begin
          r_bus_msg   <= IDLE_MSG;
          r_bus_valid <= 1'b0;
          r_grant     <= '0;
`ifdef SNOOP_BUS_TIMEOUT_EN
          r_cnt       <= '0;
`endif
          // A processor read miss keeps the bus until memory answers.
          r_state     <= (r_from_proc && (r_op == READ_MISS_OP)) ? S_WAIT_MEM : S_IDLE;
        end
        S_WAIT_MEM: begin
          if (i_mem_valid) begin
            r_bus_msg   <= i_mem_msg;
            r_bus_valid <= 1'b1;
            r_grant     <= '0;
            r_from_proc <= 1'b0;
            r_state     <= S_BCAST;
          end
`ifdef SNOOP_BUS_TIMEOUT_EN
          else if (r_cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
            r_timeout_err <= 1'b1;
            r_bus_valid   <= 1'b0;
            r_state       <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
`endif
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
